fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Parametrised program-sequencing core for the x9 CPU: owns the PC, start/halt control and the run counters.
//  Sits between ControlUnit (branch/halt requests) and instr_ROM (inst_addr_out).
//  Adds stall support, a retired-instruction counter, saturating counters and optional program-bounds checking.
// PARAMETERS
//  A         9    PC / instruction-address width; ROM depth 2**A
//  CNT_W     32   width of cycle_ct and inst_ct
//  INSTS_CNT 512  program length in instructions; used only with FETCH_BOUNDS_EN
// PORTS
//  clk             in   1      clock; all state updates on posedge clk
//  reset_n         in   1      asynchronous active-low reset
//  start           in   1      level; high = hold in LOAD, restart program
//  inst_addr_reset in   A      PC load value used in LOAD
//  ctrl_branch     in   1      current instruction is a branch
//  take_branch     in   1      branch condition true
//  inst_addr_in    in   A      branch target
//  halt_req        in   1      current instruction is HALT
//  stall           in   1      freeze PC and inst_ct this cycle
//  inst_addr_out   out  A      PC presented to instr_ROM
//  fetch_valid     out  1      1 iff state==RUN
//  halt            out  1      1 iff state!=RUN
//  cycle_ct        out  CNT_W  cycles spent in RUN
//  inst_ct         out  CNT_W  instructions retired (non-stalled RUN cycles)
//  oob_fault       out  1      PC left program bounds (tied 0 without FETCH_BOUNDS_EN)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, inst_addr_out=0, fetch_valid=0, halt=1, cycle_ct=0, inst_ct=0, oob_fault=0.
//  All outputs registered or decoded directly from registered state; no input-to-output comb paths.
//  States: IDLE, LOAD, RUN, HALTED.
//   IDLE:   start=1 -> LOAD.
//   LOAD:   each cycle PC<=inst_addr_reset; cycle_ct, inst_ct, oob_fault <= 0; start=0 -> RUN.
//   RUN:    priority: start > stall > halt_req > branch > increment.
//     start=1 -> LOAD; PC and counters unchanged this edge.
//     stall=1 -> PC holds, inst_ct holds, cycle_ct++; halt_req/branch ignored.
//     halt_req=1 -> HALTED, PC holds, inst_ct++ (HALT counts as retired).
//     ctrl_branch & take_branch -> PC<=inst_addr_in; ctrl_branch & !take_branch -> PC+1.
//     otherwise PC<=PC+1, mod 2**A (wraps 2**A-1 -> 0).
//     cycle_ct++ on every RUN cycle, including the halting cycle.
//   HALTED: PC and counters frozen; start=1 -> LOAD; no other exit.
//  Latency: start falls before edge N -> RUN after edge N; first fetch at inst_addr_reset with fetch_valid=1 in that cycle.
//   halt_req at edge M -> halt=1 after edge M.
//  Counters saturate at all-ones; no wrap.
//  reset_n asserted mid-RUN: immediate return to reset values.
//  start held across several cycles: remains in LOAD, reloading each cycle.
// CONFIGURATION
//  FETCH_BOUNDS_EN defined: in RUN, a computed next PC >= INSTS_CNT (increment or branch target) sets oob_fault=1 and state<=HALTED, PC holds.
//   oob_fault is sticky until LOAD or reset.
//  FETCH_BOUNDS_EN undefined: no bounds check; PC wraps mod 2**A; oob_fault constant 0; INSTS_CNT unused.
// TESTING
//  1 reset_n=0 mid-RUN -> next sample: PC=0, halt=1, fetch_valid=0, counters=0.
//  2 inst_addr_reset=9'd5, start 1 for 3 cycles then 0, 4 plain cycles -> PC 5,6,7,8.
//   cycle_ct=4, inst_ct=4.
//  3 PC=10, ctrl_branch=1, take_branch=1, inst_addr_in=9'd200 -> PC=200.
//   Same with take_branch=0 -> PC=11.
//  4 stall=1 for 2 cycles at PC=20, with halt_req=1 -> PC stays 20, inst_ct +0, cycle_ct +2, still RUN.
//   stall=0 with halt_req=1 -> halt=1 next cycle, inst_ct +1.
//  5 A=4, PC=15, no branch -> PC=0 (macro off).
//   Macro on, INSTS_CNT=12, PC=11 -> oob_fault=1, halt=1, PC=11.
//  6 CNT_W=4, 20 RUN cycles -> cycle_ct=15 (saturated).
//   Then start pulse -> counters 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program sequencer for the x9 CPU: PC, start/halt control, cycle and retired-instruction counters.
// Optional program-bounds checking is enabled by defining FETCH_BOUNDS_EN.
module fetch_sequencer #(
  parameter int A         = 9,
  parameter int CNT_W     = 32,
  parameter int INSTS_CNT = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [A-1:0]     inst_addr_reset,
  input  logic             ctrl_branch,
  input  logic             take_branch,
  input  logic [A-1:0]     inst_addr_in,
  input  logic             halt_req,
  input  logic             stall,
  output logic [A-1:0]     inst_addr_out,
  output logic             fetch_valid,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_ct,
  output logic [CNT_W-1:0] inst_ct,
  output logic             oob_fault
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALTED} state_t;

  state_t           state, state_nx;
  logic [A-1:0]     pc_nx;
  logic [CNT_W-1:0] cycle_nx, inst_nx;
  logic             branch_taken;

  // A program longer than the address space can never be fully fetched.
  if (INSTS_CNT < 1 || INSTS_CNT > (2 ** A)) begin : g_bad_insts_cnt
    $error("fetch_sequencer: INSTS_CNT must lie in 1..2**A");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign branch_taken = ctrl_branch && take_branch;

`ifdef FETCH_BOUNDS_EN
  localparam logic [A:0] PROG_END = (A+1)'(INSTS_CNT);
  logic       oob_q, oob_nx;
  logic [A:0] bound_next;

  // One extra bit so PC+1 past the top of the address space is still seen as out of range.
  assign bound_next = branch_taken ? {1'b0, inst_addr_in} : {1'b0, inst_addr_out} + 1'b1;
  assign oob_fault  = oob_q;
`else
  assign oob_fault  = 1'b0;
`endif

  // NOTE: every signal written here gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    pc_nx    = inst_addr_out;
    cycle_nx = cycle_ct;
    inst_nx  = inst_ct;
`ifdef FETCH_BOUNDS_EN
    oob_nx   = oob_q;
`endif
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        pc_nx    = inst_addr_reset;
        cycle_nx = '0;
        inst_nx  = '0;
`ifdef FETCH_BOUNDS_EN
        oob_nx   = 1'b0;
`endif
        if (!start) state_nx = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_nx = S_LOAD;
        end else begin
          cycle_nx = sat_inc(cycle_ct);
          if (stall) begin
            // PC and retired count hold; halt and branch wait for the stall to clear.
          end else if (halt_req) begin
            state_nx = S_HALTED;
            inst_nx  = sat_inc(inst_ct);
          end else begin
            inst_nx = sat_inc(inst_ct);
`ifdef FETCH_BOUNDS_EN
            if (bound_next >= PROG_END) begin
              oob_nx   = 1'b1;
              state_nx = S_HALTED;
            end else begin
              pc_nx = bound_next[A-1:0];
            end
`else
            pc_nx = branch_taken ? inst_addr_in : inst_addr_out + 1'b1;
`endif
          end
        end
      end
      S_HALTED: if (start) state_nx = S_LOAD;
      default:  state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      inst_addr_out <= '0;
      cycle_ct      <= '0;
      inst_ct       <= '0;
    end else begin
      state         <= state_nx;
      inst_addr_out <= pc_nx;
      cycle_ct      <= cycle_nx;
      inst_ct       <= inst_nx;
    end
  end

`ifdef FETCH_BOUNDS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) oob_q <= 1'b0;
    else          oob_q <= oob_nx;
  end
`endif

  assign fetch_valid = (state == S_RUN);
  assign halt        = !fetch_valid;

endmodule
